// File: rtl/auth_pwr_seq_pkg.sv
// Shared definitions for the BLE power-up sequencer.
// Holds the state encoding and the two command byte values that the
// sequencer decodes from the UART receive stream.
package auth_pkg;

  // Sequencer states. The encoding is what appears on state_o.
  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_PWR1 = 2'b01,
    ST_PWR2 = 2'b10
  } state_t;

  localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'
  localparam logic [7:0] CMD_STOP = 8'h53;  // 'S'

endpackage

// File: rtl/auth_pwr_seq_if.sv
// Bundle between the UART/rider side and the power-up sequencer.
//   rx_data    : received byte
//   rx_rdy     : byte valid, held until clr_rx_rdy
//   rider_off  : raw rider-absent flag from steer_en
//   clr_rx_rdy : one-cycle consume pulse
//   pwr_up     : balance/steer enable
//   state_o    : current state encoding
//   link_lost  : one-cycle watchdog expiry pulse
// master = UART/rider side, slave = sequencer.
interface auth_pwr_seq_if;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rider_off;
  logic       clr_rx_rdy;
  logic       pwr_up;
  logic [1:0] state_o;
  logic       link_lost;

  modport master (
    output rx_data, rx_rdy, rider_off,
    input  clr_rx_rdy, pwr_up, state_o, link_lost
  );

  modport slave (
    input  rx_data, rx_rdy, rider_off,
    output clr_rx_rdy, pwr_up, state_o, link_lost
  );
endinterface

// File: rtl/persist_cnt.sv
// Saturating consecutive-high counter.
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear
//   din      : level being qualified; any low cycle restarts the count
//   hit      : high once din has been high for MAX_CNT consecutive cycles
module persist_cnt #(
  parameter int unsigned MAX_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic hit
);
  localparam int CW = $clog2(MAX_CNT + 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr || !din) begin
      cnt_reg <= '0;
    end else if (cnt_reg != CW'(MAX_CNT)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign hit = (cnt_reg == CW'(MAX_CNT));
endmodule

// File: rtl/auth_pwr_seq.sv
// Power-up sequencer between the BLE UART receiver and the balance/steer
// datapath. Decodes 'G'/'S' command bytes, combines them with a debounced
// rider-absent flag and a link-loss watchdog, and drives pwr_up.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : auth_pwr_seq_if.slave (rx_data, rx_rdy, rider_off in;
//         clr_rx_rdy, pwr_up, state_o, link_lost out, all registered)
module auth_pwr_seq
  import auth_pkg::*;
#(
  parameter int unsigned OFF_DB_CYC = 1024,
  parameter int unsigned WDOG_CYC   = 50_000_000
) (
  input  logic           clk,
  input  logic           rst,
  auth_pwr_seq_if.slave  bus
);
  localparam logic [1:0] S_OFF  = ST_OFF;
  localparam logic [1:0] S_PWR1 = ST_PWR1;
  localparam logic [1:0] S_PWR2 = ST_PWR2;
  localparam int WW = $clog2(WDOG_CYC + 1);

  logic [1:0]    state_reg, state_next;
  logic [WW-1:0] wdog_reg, wdog_next;
  logic          clr_reg, pwr_reg, link_lost_reg;
  logic          take, wdog_exp, rider_gone;

  persist_cnt #(.MAX_CNT(OFF_DB_CYC)) u_rider_db (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .din (bus.rider_off),
    .hit (rider_gone)
  );

  // A byte still flagged during its own clear cycle is the same byte.
  assign take = bus.rx_rdy && !clr_reg;

  // A byte arriving on the expiry cycle wins and re-arms the watchdog.
  assign wdog_exp = (state_reg == S_PWR1) && !take &&
                    (wdog_reg == WW'(WDOG_CYC - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_OFF: begin
        if (take && bus.rx_data == CMD_GO) state_next = S_PWR1;
      end
      S_PWR1: begin
        // Rider leaving alone never drops power here; only Stop or link loss.
        if (take) begin
          if (bus.rx_data == CMD_STOP) state_next = rider_gone ? S_OFF : S_PWR2;
        end else if (wdog_exp) begin
          state_next = S_PWR2;
        end
      end
      S_PWR2: begin
        if (rider_gone)                       state_next = S_OFF;
        else if (take && bus.rx_data == CMD_GO) state_next = S_PWR1;
      end
      default: state_next = S_OFF;
    endcase
  end

  always_comb begin
    wdog_next = wdog_reg + 1'b1;
    if (state_reg != S_PWR1 || take || wdog_exp) wdog_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_OFF;
      wdog_reg      <= '0;
      clr_reg       <= 1'b0;
      pwr_reg       <= 1'b0;
      link_lost_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wdog_reg      <= wdog_next;
      clr_reg       <= take;
      pwr_reg       <= (state_next != S_OFF);
      link_lost_reg <= wdog_exp;
    end
  end

  assign bus.clr_rx_rdy = clr_reg;
  assign bus.pwr_up     = pwr_reg;
  assign bus.state_o    = state_reg;
  assign bus.link_lost  = link_lost_reg;
endmodule

// File: tb/tb_auth_pwr_seq.sv
module tb_auth_pwr_seq;
  import auth_pkg::*;

  localparam int OFF_DB = 4;
  localparam int WDOG   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  auth_pwr_seq_if bus_if ();

  auth_pwr_seq #(.OFF_DB_CYC(OFF_DB), .WDOG_CYC(WDOG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: state as an int, rider presence as a run length,
  // watchdog as the edge index at which the silent interval started.
  int     m_st = 0;
  bit     m_pwr = 0, m_clr = 0, m_ll = 0;
  int     m_ones = 0;
  longint edge_idx = 0, wd_start = 0;

  typedef struct {
    bit         rdy;
    logic [7:0] data;
    bit         off;
    logic [1:0] st;
    bit         pwr;
    bit         clr;
    bit         ll;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit gone, take, expd;
    int nst;
    edge_idx++;
    if (rst) begin
      m_st = 0; m_pwr = 0; m_clr = 0; m_ll = 0; m_ones = 0;
      wd_start = edge_idx;
    end else begin
      gone = (m_ones >= OFF_DB);
      take = bus_if.rx_rdy && !m_clr;
      expd = (m_st == 1) && !take && (edge_idx - wd_start >= WDOG);
      nst = m_st;
      if (m_st == 0) begin
        if (take && bus_if.rx_data == 8'h47) nst = 1;
      end else if (m_st == 1) begin
        if (take && bus_if.rx_data == 8'h53) nst = gone ? 0 : 2;
        else if (expd) nst = 2;
      end else begin
        if (gone) nst = 0;
        else if (take && bus_if.rx_data == 8'h47) nst = 1;
      end
      if (m_st != 1 || take || expd) wd_start = edge_idx;
      m_clr  = take;
      m_ll   = expd;
      m_ones = bus_if.rider_off ? ((m_ones < 1000) ? m_ones + 1 : m_ones) : 0;
      m_st   = nst;
      m_pwr  = (nst != 0);
    end
  endtask

  // One clock edge; outputs sampled 1 time unit after it and compared to the model.
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check("mdl_state", {6'd0, bus_if.state_o}, 8'(m_st));
    check("mdl_pwr_up", {7'd0, bus_if.pwr_up}, {7'd0, m_pwr});
    check("mdl_clr_rx_rdy", {7'd0, bus_if.clr_rx_rdy}, {7'd0, m_clr});
    check("mdl_link_lost", {7'd0, bus_if.link_lost}, {7'd0, m_ll});
  endtask

  task automatic send(input logic [7:0] b);
    bus_if.rx_rdy  = 1'b1;
    bus_if.rx_data = b;
    step();
    bus_if.rx_rdy  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] st, input bit pwr,
                         input bit clr, input bit ll);
    $display("%s: state=%0d pwr_up=%0d clr=%0d link_lost=%0d", tag,
             bus_if.state_o, bus_if.pwr_up, bus_if.clr_rx_rdy, bus_if.link_lost);
    check({tag, "_state"}, {6'd0, bus_if.state_o}, {6'd0, st});
    check({tag, "_pwr_up"}, {7'd0, bus_if.pwr_up}, {7'd0, pwr});
    check({tag, "_clr"}, {7'd0, bus_if.clr_rx_rdy}, {7'd0, clr});
    check({tag, "_link_lost"}, {7'd0, bus_if.link_lost}, {7'd0, ll});
  endtask

  initial begin
    bus_if.rx_rdy = 1'b0; bus_if.rx_data = 8'h00; bus_if.rider_off = 1'b0;

    // Reset state
    step(); step();
    chk_out("reset", 2'b00, 0, 0, 0);
    rst = 1'b0;

    // Scenarios 1 and 2: Go latency, Stop to PWR2, debounce boundary
    vecs[0]  = '{0, 8'h00, 0, 2'b00, 0, 0, 0};
    vecs[1]  = '{0, 8'h00, 0, 2'b00, 0, 0, 0};
    vecs[2]  = '{1, 8'h47, 0, 2'b01, 1, 1, 0};
    vecs[3]  = '{0, 8'h00, 0, 2'b01, 1, 0, 0};
    vecs[4]  = '{1, 8'h53, 0, 2'b10, 1, 1, 0};
    vecs[5]  = '{0, 8'h00, 1, 2'b10, 1, 0, 0};
    vecs[6]  = '{0, 8'h00, 1, 2'b10, 1, 0, 0};
    vecs[7]  = '{0, 8'h00, 1, 2'b10, 1, 0, 0};
    vecs[8]  = '{0, 8'h00, 0, 2'b10, 1, 0, 0};
    vecs[9]  = '{0, 8'h00, 1, 2'b10, 1, 0, 0};
    vecs[10] = '{0, 8'h00, 1, 2'b10, 1, 0, 0};
    vecs[11] = '{0, 8'h00, 1, 2'b10, 1, 0, 0};
    vecs[12] = '{0, 8'h00, 1, 2'b10, 1, 0, 0};
    vecs[13] = '{0, 8'h00, 0, 2'b00, 0, 0, 0};
    vecs[14] = '{1, 8'h47, 0, 2'b01, 1, 1, 0};
    vecs[15] = '{0, 8'h00, 0, 2'b01, 1, 0, 0};
    for (int i = 0; i < 16; i++) begin
      bus_if.rx_rdy    = vecs[i].rdy;
      bus_if.rx_data   = vecs[i].data;
      bus_if.rider_off = vecs[i].off;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].pwr, vecs[i].clr, vecs[i].ll);
    end

    // Scenario 3: rider gone without Stop keeps PWR1; Stop lands on the
    // expiry cycle and must win, going straight to OFF.
    bus_if.rider_off = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      check("s3_hold_state", {6'd0, bus_if.state_o}, 8'd1);
    end
    send(8'h53);
    chk_out("s3_stop", 2'b00, 0, 1, 0);
    bus_if.rider_off = 1'b0;
    step();

    // Scenario 4: watchdog expiry, then kept alive by unknown bytes
    send(8'h47);
    for (int i = 0; i < 15; i++) begin
      step();
      check("s4_no_expiry", {7'd0, bus_if.link_lost}, 8'd0);
    end
    step();
    chk_out("s4_expiry", 2'b10, 1, 0, 1);
    step();
    chk_out("s4_after", 2'b10, 1, 0, 0);
    send(8'h47);
    for (int i = 0; i < 40; i++) begin
      bus_if.rx_rdy  = (i % 10 == 5);
      bus_if.rx_data = 8'h41;
      step();
      check("s4_keepalive_ll", {7'd0, bus_if.link_lost}, 8'd0);
      check("s4_keepalive_st", {6'd0, bus_if.state_o}, 8'd1);
    end
    bus_if.rx_rdy = 1'b0;

    // Scenario 5: rider_gone beats Go in PWR2; rx_rdy held two cycles
    send(8'h53);
    chk_out("s5_pwr2", 2'b10, 1, 1, 0);
    bus_if.rider_off = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("s5_before_gone", {6'd0, bus_if.state_o}, 8'd2);
    bus_if.rx_rdy = 1'b1; bus_if.rx_data = 8'h47;
    step();
    chk_out("s5_gone_vs_go", 2'b00, 0, 1, 0);
    step();
    chk_out("s5_no_redecode", 2'b00, 0, 0, 0);
    bus_if.rx_rdy = 1'b0; bus_if.rider_off = 1'b0;
    step();

    // Scenario 6: reset mid-ride with a byte pending
    send(8'h47);
    step(); step();
    bus_if.rx_rdy = 1'b1; bus_if.rx_data = 8'h53;
    rst = 1'b1;
    step();
    chk_out("s6_reset", 2'b00, 0, 0, 0);
    rst = 1'b0;
    step();
    chk_out("s6_stop_in_off", 2'b00, 0, 1, 0);
    bus_if.rx_rdy = 1'b0;
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (bus_if.rx_rdy) begin
        if (m_clr && $urandom_range(0, 3) != 0) bus_if.rx_rdy = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        bus_if.rx_rdy = 1'b1;
        case ($urandom_range(0, 3))
          0: bus_if.rx_data = 8'h47;
          1: bus_if.rx_data = 8'h53;
          2: bus_if.rx_data = 8'h41;
          default: bus_if.rx_data = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 9) == 0) bus_if.rider_off = ~bus_if.rider_off;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
